// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one load/store at a time between EX/MEM and data memory, flagging faults.
// Optional MEM_PERF_CNT_EN adds load/store/fault/busy performance counters.
module mem_access_ctrl #(
    parameter int READ_LATENCY = 1,
    parameter int MEM_BYTES    = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_re,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [2:0]  req_func3,
    input  logic [4:0]  req_rd,
    output logic        dmem_we,
    output logic        dmem_re,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_data,
    output logic [2:0]  dmem_func3,
    input  logic [63:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        exc_valid,
    output logic [3:0]  exc_cause,
    output logic [63:0] exc_addr
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_faults,
    output logic [31:0] perf_busy
`endif
);
    typedef enum logic [2:0] {IDLE, STORE, LOAD_WAIT, RESP, EXC} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d, data_q, data_d, wb_data_q, wb_data_d, exc_addr_q, exc_addr_d;
    logic [2:0]  func3_q, func3_d;
    logic [4:0]  rd_q, rd_d;
    logic [3:0]  cause_q, cause_d;
    logic [1:0]  sz;
    logic [2:0]  mask;
    logic [3:0]  nbytes;
    logic        mis, oor, acc, acc_st, acc_ld, acc_flt, rd_done;

    // Alignment mask has one bit per low address bit the access size must leave clear.
    always_comb begin
        sz      = req_func3[1:0];
        mask    = {&sz, sz[1], |sz};
        nbytes  = 4'd1 << sz;
        mis     = |(req_addr[2:0] & mask);
        oor     = ({1'b0, req_addr} + {61'd0, nbytes}) > 65'(MEM_BYTES);
        acc     = req_valid && state_q == IDLE && (req_we || req_re);
        acc_flt = acc && (mis || oor);
        acc_st  = acc && !acc_flt && req_we;
        acc_ld  = acc && !acc_flt && !req_we;
        rd_done = state_q == LOAD_WAIT && cnt_q == 2'(READ_LATENCY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            func3_q    <= '0;
            rd_q       <= '0;
            wb_data_q  <= '0;
            cause_q    <= '0;
            exc_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            func3_q    <= func3_d;
            rd_q       <= rd_d;
            wb_data_q  <= wb_data_d;
            cause_q    <= cause_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = acc_flt ? EXC : acc_st ? STORE : acc_ld ? LOAD_WAIT : IDLE;
            LOAD_WAIT: state_d = rd_done ? RESP : LOAD_WAIT;
            default:   state_d = IDLE;
        endcase
        cnt_d      = acc_ld ? 2'd0 : state_q == LOAD_WAIT ? cnt_q + 2'd1 : cnt_q;
        addr_d     = (acc_st || acc_ld) ? req_addr : addr_q;
        func3_d    = (acc_st || acc_ld) ? req_func3 : func3_q;
        data_d     = acc_st ? req_wdata : data_q;
        rd_d       = acc_ld ? req_rd : rd_q;
        wb_data_d  = rd_done ? dmem_rdata : wb_data_q;
        cause_d    = acc_flt ? {2'b01, req_we, !mis} : cause_q;
        exc_addr_d = acc_flt ? req_addr : exc_addr_q;
    end

    always_comb begin
        req_ready  = state_q == IDLE;
        dmem_we    = state_q == STORE;
        dmem_re    = state_q == LOAD_WAIT;
        wb_valid   = state_q == RESP;
        exc_valid  = state_q == EXC;
        dmem_addr  = addr_q;
        dmem_data  = data_q;
        dmem_func3 = func3_q;
        wb_rd      = rd_q;
        wb_data    = wb_data_q;
        exc_cause  = cause_q;
        exc_addr   = exc_addr_q;
    end

`ifdef MEM_PERF_CNT_EN
    logic [31:0] loads_q, stores_q, faults_q, busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loads_q  <= '0;
            stores_q <= '0;
            faults_q <= '0;
            busy_q   <= '0;
        end else begin
            loads_q  <= loads_q + 32'(acc_ld);
            stores_q <= stores_q + 32'(acc_st);
            faults_q <= faults_q + 32'(acc_flt);
            busy_q   <= busy_q + 32'(state_q != IDLE);
        end
    end

    assign perf_loads  = loads_q;
    assign perf_stores = stores_q;
    assign perf_faults = faults_q;
    assign perf_busy   = busy_q;
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random load/store checks against a byte-array reference model.
module tb_mem_access_ctrl;
    localparam int RL = 1;
    localparam int MB = 2048;

    logic        clk, rst, req_valid, req_ready, req_we, req_re;
    logic [63:0] req_addr, req_wdata, dmem_addr, dmem_data, dmem_rdata, wb_data, exc_addr;
    logic [2:0]  req_func3, dmem_func3;
    logic [4:0]  req_rd, wb_rd;
    logic        dmem_we, dmem_re, wb_valid, exc_valid;
    logic [3:0]  exc_cause;
`ifdef MEM_PERF_CNT_EN
    logic [31:0] perf_loads, perf_stores, perf_faults, perf_busy;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0]  bram [MB];
    logic [7:0]  ref_mem [MB];
    logic [63:0] raw;

    mem_access_ctrl #(.READ_LATENCY(RL), .MEM_BYTES(MB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_re(req_re),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3), .req_rd(req_rd),
        .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_addr(dmem_addr), .dmem_data(dmem_data),
        .dmem_func3(dmem_func3), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
`ifdef MEM_PERF_CNT_EN
        ,
        .perf_loads(perf_loads), .perf_stores(perf_stores),
        .perf_faults(perf_faults), .perf_busy(perf_busy)
`endif
    );

    always #5 clk = ~clk;

    // Memory environment: 64-bit word BRAM with one-cycle read, then a combinational load unit.
    function automatic logic [63:0] word_at(input logic [10:0] a);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = bram[{a[10:3], 3'b000} + 11'(k)];
        return w;
    endfunction

    function automatic logic [63:0] load_unit(input logic [63:0] w, input logic [2:0] off, input logic [2:0] f);
        logic [63:0] s;
        s = w >> (8 * off);
        case (f[1:0])
            2'd0:    return f[2] ? {56'd0, s[7:0]} : {{56{s[7]}}, s[7:0]};
            2'd1:    return f[2] ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            2'd2:    return f[2] ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default: return s;
        endcase
    endfunction

    always @(posedge clk) begin
        if (dmem_we)
            for (int k = 0; k < (1 << dmem_func3[1:0]); k++) bram[dmem_addr[10:0] + 11'(k)] <= dmem_data[8*k +: 8];
        if (dmem_re) raw <= word_at(dmem_addr[10:0]);
    end

    assign dmem_rdata = load_unit(raw, dmem_addr[2:0], dmem_func3);

    function automatic int ref_cause(input bit we, input logic [63:0] a, input logic [2:0] f);
        longint n;
        n = longint'(1) << f[1:0];
        if (a % n != 0) return we ? 6 : 4;
        if (a + n > MB) return we ? 7 : 5;
        return 0;
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [2:0] f);
        int n;
        logic [63:0] v;
        n = 1 << f[1:0];
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[int'(a) + k];
        if (!f[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] a, input logic [63:0] d, input logic [2:0] f);
        for (int k = 0; k < (1 << f[1:0]); k++) ref_mem[int'(a) + k] = d[8*k +: 8];
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit we, input bit re, input logic [63:0] a,
                         input logic [63:0] d, input logic [2:0] f, input logic [4:0] rd);
        req_valid = v;
        req_we    = we;
        req_re    = re;
        req_addr  = a;
        req_wdata = d;
        req_func3 = f;
        req_rd    = rd;
    endtask

    task automatic junk();
        drive(1, 1'($urandom), 1, {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom), 5'($urandom));
    endtask

    // Call at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic req(input bit we, input bit re, input logic [63:0] a, input logic [63:0] d,
                       input logic [2:0] f, input logic [4:0] rd);
        int c;
        chk("ready_before", req_ready, 1);
        drive(1, we, re, a, d, f, rd);
        @(negedge clk);
        c = ref_cause(we, a, f);
        if (!we && !re) begin
            req_valid = 0;
            chk("nop_ready", req_ready, 1);
            chk("nop_strobe", {dmem_we, dmem_re, wb_valid, exc_valid}, 0);
        end else if (c != 0) begin
            junk();
            chk("exc_valid", exc_valid, 1);
            chk("exc_cause", exc_cause, 64'(c));
            chk("exc_addr", exc_addr, a);
            chk("exc_no_dmem", {dmem_we, dmem_re, req_ready}, 0);
            @(negedge clk);
            req_valid = 0;
            chk("exc_pulse", exc_valid, 0);
            chk("exc_ready", req_ready, 1);
        end else if (we) begin
            junk();
            ref_store(a, d, f);
            chk("st_we", {dmem_we, dmem_re, req_ready}, 3'b100);
            chk("st_addr", dmem_addr, a);
            chk("st_data", dmem_data, d);
            chk("st_func3", dmem_func3, 64'(f));
            @(negedge clk);
            req_valid = 0;
            chk("st_we_drop", dmem_we, 0);
            chk("st_ready", req_ready, 1);
        end else begin
            junk();
            for (int i = 0; i <= RL; i++) begin
                chk("ld_re", {dmem_re, wb_valid, req_ready}, 3'b100);
                chk("ld_addr", dmem_addr, a);
                chk("ld_func3", dmem_func3, 64'(f));
                @(negedge clk);
            end
            chk("ld_wb_valid", {wb_valid, dmem_re}, 2'b10);
            chk("ld_wb_data", wb_data, ref_load(a, f));
            chk("ld_wb_rd", wb_rd, 64'(rd));
            chk("ld_resp_func3", dmem_func3, 64'(f));
            chk("ld_resp_addr", dmem_addr, a);
            @(negedge clk);
            req_valid = 0;
            chk("ld_wb_pulse", wb_valid, 0);
            chk("ld_ready", req_ready, 1);
            chk("ld_data_hold", wb_data, ref_load(a, f));
        end
    endtask

    initial begin
        int pulses, last;
        bit we, re;
        logic [2:0] f;
        logic [63:0] a;
        for (int i = 0; i < MB; i++) begin
            bram[i] = '0;
            ref_mem[i] = '0;
        end
        raw = '0;
        clk = 0;
        rst = 1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_strobes", {dmem_we, dmem_re, wb_valid, exc_valid}, 0);
        chk("rst_dmem", dmem_addr | dmem_data | 64'(dmem_func3), 0);
        chk("rst_wb", wb_data | 64'(wb_rd), 0);
        chk("rst_exc", exc_addr | 64'(exc_cause), 0);

        req(1, 0, 64'h10, 64'h1122334455667788, 3'd3, 5'd0);
        req(0, 1, 64'h10, 0, 3'd3, 5'd9);
        req(0, 1, 64'h17, 0, 3'd0, 5'd3);
        chk("lb_value", wb_data, 64'h11);
        req(0, 1, 64'h12, 0, 3'd2, 5'd4);
        chk("lw_mis_cause", exc_cause, 4);
        req(1, 0, 64'h800, 64'hdead, 3'd3, 5'd0);
        chk("sd_oor_cause", exc_cause, 7);
        req(0, 1, 64'h7f8, 0, 3'd3, 5'd1);
        req(0, 1, 64'h7fc, 0, 3'd3, 5'd1);
        req(0, 1, 64'h7fe, 0, 3'd1, 5'd1);
        req(0, 0, 64'h20, 0, 3'd3, 5'd1);

        drive(1, 0, 1, 64'h10, 0, 3'd3, 5'd7);
        @(negedge clk);
        req_valid = 0;
        chk("abort_re_before", dmem_re, 1);
        rst = 1;
        #1;
        chk("abort_re_async", dmem_re, 0);
        chk("abort_wb", wb_valid, 0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_quiet", {wb_valid, exc_valid, dmem_re, req_ready}, 4'b0001);
        end

        pulses = 0;
        last = 0;
        drive(1, 1, 0, 64'h100, 64'ha0, 3'd3, 5'd0);
        for (int c = 0; c < 20 && pulses < 3; c++) begin
            @(negedge clk);
            if (dmem_we) begin
                chk("b2b_addr", dmem_addr, 64'h100 + 64'(8 * pulses));
                chk("b2b_data", dmem_data, 64'ha0 + 64'(pulses));
                if (pulses > 0) chk("b2b_gap", 64'(c - last), 2);
                ref_store(64'h100 + 64'(8 * pulses), 64'ha0 + 64'(pulses), 3'd3);
                last = c;
                pulses++;
                if (pulses == 3) req_valid = 0;
                else drive(1, 1, 0, 64'h100 + 64'(8 * pulses), 64'ha0 + 64'(pulses), 3'd3, 5'd0);
            end
        end
        chk("b2b_count", 64'(pulses), 3);
        @(negedge clk);
        chk("b2b_idle", {req_ready, dmem_we}, 2'b10);
`ifdef MEM_PERF_CNT_EN
        chk("perf_stores", 64'(perf_stores), 3);
        chk("perf_busy", 64'(perf_busy), 3);
        chk("perf_loads", 64'(perf_loads), 0);
        chk("perf_faults", 64'(perf_faults), 0);
`endif
        req(0, 1, 64'h108, 0, 3'd3, 5'd2);

        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom);
            re = $urandom_range(0, 5) != 0;
            f = we ? {1'b0, 2'($urandom)} : 3'($urandom);
            a = ($urandom_range(0, 5) == 0) ? 64'($urandom_range(2030, 2060)) : 64'($urandom_range(0, 95));
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f[1:0]) - 64'd1);
            req(we, re, a, {$urandom, $urandom}, f, 5'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequencing stage between the EX/MEM pipeline register and the data-memory block (store unit → 64-bit BRAM → load unit).
- Accepts one load/store request at a time over a valid/ready handshake.
- Registers and holds address, data and func3 to the data memory across the BRAM read latency, captures load results, and presents them to writeback.
- Detects misaligned and out-of-range accesses; these raise an exception instead of touching memory.

Parameters:
- READ_LATENCY, 1: BRAM read latency in cycles, from address sampled to douta valid; legal range 1..3.
- MEM_BYTES, 2048: addressable bytes (256 words x 8); any access with addr >= MEM_BYTES faults.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  store request.
- req_re  in  1  load request.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data.
- req_func3  in  3  RISC-V load/store func3.
- req_rd  in  5  load destination register.
- dmem_we  out  1  to data memory: write enable.
- dmem_re  out  1  to data memory: read enable.
- dmem_addr  out  64  to data memory: byte address.
- dmem_data  out  64  to data memory: store data.
- dmem_func3  out  3  to data memory: func3.
- dmem_rdata  in  64  from data memory: sign/zero-extended load data.
- wb_valid  out  1  one-cycle pulse: load result valid.
- wb_rd  out  5  destination register of the load result.
- wb_data  out  64  load result.
- exc_valid  out  1  one-cycle pulse: access exception.
- exc_cause  out  4  4 = load misaligned, 5 = load access fault, 6 = store misaligned, 7 = store access fault.
- exc_addr  out  64  faulting address.

Behaviour:
- Reset: state IDLE, counter 0; every output 0 except req_ready = 1 after reset deasserts.
- Reset during an operation aborts it immediately: dmem_we/dmem_re drop asynchronously, no wb_valid, no exc_valid.
- States:
  - IDLE: req_ready = 1.
  - STORE, LOAD_WAIT, RESP, EXC: req_ready = 0.
- Accept occurs on an edge where req_valid && req_ready.
- Decode at accept:
  - req_we has priority over req_re.
  - Neither set: NOP; accepted, remain in IDLE, no effect.
- Access size = func3[1:0]: 0 = byte, 1 = half, 2 = word, 3 = double.
- Misaligned: half with addr[0] != 0; word with addr[1:0] != 0; double with addr[2:0] != 0.
- Out of range: addr + size_bytes > MEM_BYTES. Misalignment is checked first.
- Fault at accept → EXC for one cycle:
  - exc_valid = 1, with cause and addr registered.
  - No dmem strobe.
  - Then IDLE.
- Aligned store at accept → STORE for one cycle:
  - dmem_we = 1; dmem_addr, dmem_data, dmem_func3 registered from req.
  - Then IDLE; dmem_we returns to 0.
  - Throughput: one store per 2 cycles.
- Aligned load at accept → LOAD_WAIT:
  - dmem_re = 1; dmem_addr, dmem_func3 and rd registered; counter cleared.
  - Each edge in LOAD_WAIT increments the counter.
  - When the counter equals READ_LATENCY: capture dmem_rdata into wb_data, go to RESP, drop dmem_re.
  - dmem_addr and dmem_func3 stay constant through LOAD_WAIT and RESP, because the load unit extends combinationally from func3.
- RESP: wb_valid = 1 for exactly one cycle, then IDLE.
- Load latency: wb_valid is high in the cycle after edge E(READ_LATENCY+1), counting the accept edge as E0.
  - READ_LATENCY = 1: wb_valid asserts 2 edges after accept.
  - Throughput: one load per READ_LATENCY + 3 cycles.
- wb_data, wb_rd, exc_cause and exc_addr hold their last values between pulses. dmem_data holds its last value.
- req_* changes while req_ready = 0 are ignored.

Optional Feature:
- Macro MEM_PERF_CNT_EN.
- Defined: adds 32-bit outputs perf_loads, perf_stores, perf_faults and perf_busy.
  - perf_loads, perf_stores, perf_faults increment once per accepted load, store and fault respectively.
  - perf_busy increments on every cycle with req_ready = 0.
  - All counters wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent; core behaviour is identical.

Test Plan:
- sd of 0x1122334455667788 at 0x10, then ld at 0x10 (READ_LATENCY = 1):
  - dmem_we pulses one cycle.
  - wb_valid asserts 2 edges after the load accept, with wb_data = 0x1122334455667788 and wb_rd = req_rd.
- lb at 0x17 after the above store → wb_data = 0x0000000000000011. dmem_func3 = 0 is held through RESP.
- lw at 0x12 → exc_valid for one cycle, exc_cause = 4, exc_addr = 0x12; dmem_re never asserts.
- sd at 0x800 (MEM_BYTES = 2048) → exc_cause = 7; dmem_we stays 0.
- Assert rst mid LOAD_WAIT → dmem_re = 0 immediately; no wb_valid follows; req_ready = 1 after release.
- Back-to-back req_valid held high with 3 stores → accepts spaced 2 cycles apart; with MEM_PERF_CNT_EN defined, perf_stores = 3 and perf_busy = 3.
